// File: rtl/cvp14_mem_pkg.sv
// Shared sizing defaults and dump FSM encoding for the CVP14 DRAM responder.
package cvp14_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 1024;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_RUN  = 2'd1,
        DS_DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/cvp14_sp_ram.sv
// Single-port synchronous RAM: one write port and one registered, read-enabled read port.
module cvp14_sp_ram #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write; rdata only moves on an enabled read.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cvp14_dram_responder.sv
// CVP14 memory-side responder: CPU read/write decode with Err, plus a valid/ready
// full-array dump engine that only uses the RAM port in cycles the CPU leaves idle.
module cvp14_dram_responder
    import cvp14_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Err,
    input  logic              DumpStart,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpDone
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    dump_state_e       state_q;
    logic [PW-1:0]     ptr_q;
    logic              dvalid_q, done_q, err_q;
    logic [ADDR_W-1:0] daddr_q;
    logic              cpu_rd_q, dump_ld_q;
    logic [DATA_W-1:0] dout_hold_q, ddata_hold_q;
    logic [DATA_W-1:0] dout_d, ddata_d, ram_rdata;

    logic          cpu_act, cpu_inr, cpu_rd_ok, cpu_wr_ok, dump_ld, dump_acc;
    logic [AW-1:0] ram_addr;

    assign cpu_act   = RD | WR;
    assign cpu_inr   = {1'b0, Addr} < (ADDR_W+1)'(DEPTH);
    assign cpu_wr_ok = WR & cpu_inr;
    assign cpu_rd_ok = RD & ~WR & cpu_inr;
    assign dump_acc  = dvalid_q & DumpReady;
    assign dump_ld   = (state_q == DS_RUN) & ~cpu_act & (ptr_q < PW'(DEPTH))
                     & (~dvalid_q | DumpReady);
    assign ram_addr  = cpu_act ? Addr[AW-1:0] : ptr_q[AW-1:0];

    cvp14_sp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk_i   (Clk1),
        .we_i    (cpu_wr_ok),
        .re_i    (cpu_rd_ok | dump_ld),
        .addr_i  (ram_addr),
        .wdata_i (DataIn),
        .rdata_o (ram_rdata)
    );

    // The shared RAM read register serves both consumers, so each output shows it only
    // in the cycle right after its own read and otherwise replays its hold register.
    assign dout_d  = cpu_rd_q  ? ram_rdata : dout_hold_q;
    assign ddata_d = dump_ld_q ? ram_rdata : ddata_hold_q;

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state_q      <= DS_IDLE;
            ptr_q        <= '0;
            dvalid_q     <= 1'b0;
            daddr_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_rd_q     <= 1'b0;
            dump_ld_q    <= 1'b0;
            dout_hold_q  <= '0;
            ddata_hold_q <= '0;
        end else begin
            err_q        <= cpu_act & ((RD & WR) | ~cpu_inr);
            cpu_rd_q     <= cpu_rd_ok;
            dump_ld_q    <= dump_ld;
            dout_hold_q  <= dout_d;
            ddata_hold_q <= ddata_d;
            done_q       <= 1'b0;
            case (state_q)
                DS_IDLE: begin
                    if (DumpStart) begin
                        state_q <= DS_RUN;
                        ptr_q   <= '0;
                    end
                end
                DS_RUN: begin
                    if (dump_acc && daddr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q  <= DS_DONE;
                        dvalid_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (dump_ld) begin
                        dvalid_q <= 1'b1;
                        daddr_q  <= ADDR_W'(ptr_q);
                        ptr_q    <= ptr_q + PW'(1);
                    end else if (dump_acc) begin
                        dvalid_q <= 1'b0;
                    end
                end
                DS_DONE: state_q <= DS_IDLE;
                default: state_q <= DS_IDLE;
            endcase
        end
    end

    assign DataOut   = dout_d;
    assign Err       = err_q;
    assign DumpValid = dvalid_q;
    assign DumpAddr  = daddr_q;
    assign DumpData  = ddata_d;
    assign DumpDone  = done_q;

endmodule
